// File: rtl/spk_output_sequencer.sv
// Speaker power-up/mute/fault sequencer between PDM source and driver.
// Ramps with a 0101 idle pattern; retries overloads, then latches a lock.
module spk_output_sequencer #(
  parameter int WARMUP_CYCLES   = 256,
  parameter int DRAIN_CYCLES    = 64,
  parameter int COOLDOWN_CYCLES = 4096,
  parameter int MAX_RETRIES     = 3
) (
  input  logic       pdm_clk,
  input  logic       rst_n,
  input  logic       req_enable,
  input  logic       src_pdm,
  input  logic       src_valid,
  input  logic       drv_overload,
  output logic       drv_pdm,
  output logic       drv_valid,
  output logic       drv_enable,
  output logic       ready,
  output logic       fault_lock,
  output logic [3:0] retry_cnt,
  output logic [2:0] state
);

  localparam int CM0  = (WARMUP_CYCLES > DRAIN_CYCLES) ?
                        WARMUP_CYCLES : DRAIN_CYCLES;
  localparam int CMAX = (CM0 > COOLDOWN_CYCLES) ? CM0 : COOLDOWN_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WARMUP = 3'd1,
    S_PLAY   = 3'd2,
    S_DRAIN  = 3'd3,
    S_COOL   = 3'd4,
    S_LOCKED = 3'd5
  } st_e;

  st_e           st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tog_q, tog_d;
  logic [3:0]    retry_q, retry_d;
  logic          pdm_q, pdm_d;
  logic          val_q, val_d;
  logic          en_q, en_d;
  logic          rdy_q, rdy_d;
  logic          lck_q, lck_d;
  logic          w_done, d_done, c_done, entry;
  st_e           ovl_st;
  logic [3:0]    ovl_retry;

  assign w_done = cnt_q == CW'(WARMUP_CYCLES - 1);
  assign d_done = cnt_q == CW'(DRAIN_CYCLES - 1);
  assign c_done = cnt_q == CW'(COOLDOWN_CYCLES - 1);

  // Saturating retry: once the budget is spent the next overload locks.
  always_comb begin
    ovl_st    = S_LOCKED;
    ovl_retry = retry_q;
    if (retry_q < 4'(MAX_RETRIES)) begin
      ovl_st    = S_COOL;
      ovl_retry = retry_q + 4'd1;
    end
  end

  always_comb begin
    st_d    = st_q;
    retry_d = retry_q;
    unique case (st_q)
      S_IDLE: if (req_enable) st_d = S_WARMUP;
      S_WARMUP: begin
        if (drv_overload) begin
          st_d    = ovl_st;
          retry_d = ovl_retry;
        end else if (!req_enable) st_d = S_IDLE;
        else if (w_done)          st_d = S_PLAY;
      end
      S_PLAY: begin
        if (drv_overload) begin
          st_d    = ovl_st;
          retry_d = ovl_retry;
        end else if (!req_enable) st_d = S_DRAIN;
      end
      S_DRAIN: if (d_done) st_d = S_IDLE;
      S_COOL: if (c_done) st_d = req_enable ? S_WARMUP : S_IDLE;
      S_LOCKED: if (!req_enable) st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
    if (st_d == S_IDLE) retry_d = 4'd0;

    entry = st_d != st_q;
    cnt_d = cnt_q;
    if (entry) cnt_d = '0;
    else if (st_q == S_WARMUP || st_q == S_DRAIN || st_q == S_COOL)
      cnt_d = cnt_q + CW'(1);
    tog_d = entry ? 1'b0 : ~tog_q;

    // Outputs follow the next state so they line up with state_q.
    pdm_d = 1'b0;
    val_d = 1'b0;
    en_d  = 1'b0;
    rdy_d = 1'b0;
    lck_d = 1'b0;
    unique case (st_d)
      S_WARMUP, S_DRAIN: begin
        en_d  = 1'b1;
        val_d = 1'b1;
        pdm_d = tog_d;
      end
      S_PLAY: begin
        en_d  = 1'b1;
        pdm_d = src_pdm;
        val_d = src_valid;
        rdy_d = 1'b1;
      end
      S_LOCKED: lck_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge pdm_clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= S_IDLE;
      cnt_q   <= '0;
      tog_q   <= 1'b0;
      retry_q <= 4'd0;
      pdm_q   <= 1'b0;
      val_q   <= 1'b0;
      en_q    <= 1'b0;
      rdy_q   <= 1'b0;
      lck_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      tog_q   <= tog_d;
      retry_q <= retry_d;
      pdm_q   <= pdm_d;
      val_q   <= val_d;
      en_q    <= en_d;
      rdy_q   <= rdy_d;
      lck_q   <= lck_d;
    end
  end

  assign drv_pdm    = pdm_q;
  assign drv_valid  = val_q;
  assign drv_enable = en_q;
  assign ready      = rdy_q;
  assign fault_lock = lck_q;
  assign retry_cnt  = retry_q;
  assign state      = st_q;

endmodule
